// File: rtl/r88_alu_seq_pkg.sv
// Shared definitions for the Rocket88 ALU micro-sequencer: op codes,
// sequencer states, flag bit positions and small op-classification helpers.
package r88_alu_seq_pkg;

    typedef enum logic [2:0] {
        R88_ALU_PASS = 3'd0,
        R88_ALU_SHL  = 3'd1,
        R88_ALU_SHR  = 3'd2,
        R88_ALU_ADD  = 3'd3,
        R88_ALU_SUB  = 3'd4,
        R88_ALU_OR   = 3'd5,
        R88_ALU_AND  = 3'd6,
        R88_ALU_XOR  = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

    // Bit positions inside the packed flag register
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;

    // Shifts and arithmetic produce a meaningful carry; pass and logic ops do not
    function automatic logic op_updates_carry(input logic [2:0] op);
        op_updates_carry = (op >= 3'd1) && (op <= 3'd4);
    endfunction

    // Right shift must walk the operand from the most significant byte down
    function automatic logic op_counts_down(input logic [2:0] op);
        op_counts_down = (op == 3'd2);
    endfunction

endpackage

// File: rtl/r88_alu_seq_flag_unit.sv
// Flag unit: accumulates zero/negative/carry information across the bytes of
// a chained command and commits it to the C/Z/N flag register at the end.
module r88_alu_seq_flag_unit
    import r88_alu_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,        // new command accepted
    input  logic       wb_en,      // write-back cycle of one byte
    input  logic       commit,     // end of command with flag write enabled
    input  logic       carry_upd,  // command op owns the carry flag
    input  logic       alu_carry,
    input  logic [7:0] int_d,
    output logic       chain_c,
    output logic       flag_c,
    output logic       flag_z,
    output logic       flag_n
);

    logic       z_acc_r;
    logic       n_last_r;
    logic       chain_c_r;
    logic [2:0] flags_r;
    logic [2:0] flags_nxt_s;

    // Per-byte accumulation: any non-zero byte clears Z, last byte supplies N, carry ripples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_acc_r   <= 1'b0;
            n_last_r  <= 1'b0;
            chain_c_r <= 1'b0;
        end else if (clr) begin
            z_acc_r   <= 1'b0;
            n_last_r  <= 1'b0;
            chain_c_r <= 1'b0;
        end else if (wb_en) begin
            z_acc_r   <= z_acc_r | (|int_d);
            n_last_r  <= int_d[7];
            chain_c_r <= alu_carry;
        end else begin
            z_acc_r   <= z_acc_r;
            n_last_r  <= n_last_r;
            chain_c_r <= chain_c_r;
        end
    end

    // Next flag value: Z and N always follow the command, C only for carry-producing ops
    always_comb begin
        flags_nxt_s = flags_r;
        if (commit) begin
            flags_nxt_s[FLAG_Z] = ~z_acc_r;
            flags_nxt_s[FLAG_N] = n_last_r;
            if (carry_upd) begin
                flags_nxt_s[FLAG_C] = chain_c_r;
            end else begin
                flags_nxt_s[FLAG_C] = flags_r[FLAG_C];
            end
        end else begin
            flags_nxt_s = flags_r;
        end
    end

    // Flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_r <= 3'b000;
        end else begin
            flags_r <= flags_nxt_s;
        end
    end

    assign chain_c = chain_c_r;
    assign flag_c  = flags_r[FLAG_C];
    assign flag_z  = flags_r[FLAG_Z];
    assign flag_n  = flags_r[FLAG_N];

endmodule

// File: rtl/r88_alu_seq.sv
// Rocket88 ALU micro-sequencer. Takes one command per valid/ready handshake,
// steps the ALU through 1..2^LEN_W bytes (EXEC then WB per byte), strobes the
// destination write and hands flag bookkeeping to the flag unit.
module r88_alu_seq
    import r88_alu_seq_pkg::*;
#(
    parameter int LEN_W = 2
) (
    input  logic             sysClock,
    input  logic             sysReset_n,
    input  logic             cmdValid,
    output logic             cmdReady,
    input  logic [2:0]       cmdOp,
    input  logic             cmdRightSel,
    input  logic             cmdCarryInEn,
    input  logic             cmdInv,
    input  logic             cmdFlagWe,
    input  logic [LEN_W-1:0] cmdLen,
    output logic [2:0]       aluOp,
    output logic             rightSel,
    output logic             carryInEn,
    output logic             carryIn,
    output logic             invOut,
    output logic             aluResult,
    input  logic             aluCarryOut,
    input  logic [7:0]       intD,
    output logic [LEN_W-1:0] byteIdx,
    output logic             dstWe,
    output logic             busy,
    output logic             done,
    output logic             flagC,
    output logic             flagZ,
    output logic             flagN
);

    seq_state_t       state_r;
    seq_state_t       state_nxt_s;
    logic [2:0]       op_r;
    logic             rsel_r;
    logic             cie_r;
    logic             inv_r;
    logic             fwe_r;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] idx_r;
    logic             first_r;
    logic             accept_s;
    logic             last_s;
    logic             in_wb_s;
    logic             commit_s;
    logic             carry_upd_s;
    logic             chain_c_s;

    assign accept_s    = cmdValid & cmdReady;
    assign last_s      = op_counts_down(op_r) ? (idx_r == {LEN_W{1'b0}}) : (idx_r == len_r);
    assign in_wb_s     = (state_r == ST_WB);
    assign commit_s    = (state_r == ST_DONE) & fwe_r;
    assign carry_upd_s = op_updates_carry(op_r);
    assign byteIdx     = idx_r;

    // State register
    always_ff @(posedge sysClock or negedge sysReset_n) begin
        if (!sysReset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: one EXEC/WB pair per byte, DONE for one cycle at the end
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_nxt_s = ST_EXEC;
                else          state_nxt_s = ST_IDLE;
            end
            ST_EXEC: state_nxt_s = ST_WB;
            ST_WB: begin
                if (last_s) state_nxt_s = ST_DONE;
                else        state_nxt_s = ST_EXEC;
            end
            ST_DONE: begin
                if (accept_s) state_nxt_s = ST_EXEC;
                else          state_nxt_s = ST_IDLE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Command latch: fields are captured only on an accepted handshake
    always_ff @(posedge sysClock or negedge sysReset_n) begin
        if (!sysReset_n) begin
            op_r   <= 3'd0;
            rsel_r <= 1'b0;
            cie_r  <= 1'b0;
            inv_r  <= 1'b0;
            fwe_r  <= 1'b0;
            len_r  <= {LEN_W{1'b0}};
        end else if (accept_s) begin
            op_r   <= cmdOp;
            rsel_r <= cmdRightSel;
            cie_r  <= cmdCarryInEn;
            inv_r  <= cmdInv;
            fwe_r  <= cmdFlagWe;
            len_r  <= cmdLen;
        end else begin
            op_r   <= op_r;
            rsel_r <= rsel_r;
            cie_r  <= cie_r;
            inv_r  <= inv_r;
            fwe_r  <= fwe_r;
            len_r  <= len_r;
        end
    end

    // Byte index: starts at 0 (or cmdLen for shr) and steps once per completed byte
    always_ff @(posedge sysClock or negedge sysReset_n) begin
        if (!sysReset_n) begin
            idx_r   <= {LEN_W{1'b0}};
            first_r <= 1'b0;
        end else if (accept_s) begin
            idx_r   <= op_counts_down(cmdOp) ? cmdLen : {LEN_W{1'b0}};
            first_r <= 1'b1;
        end else if (in_wb_s && !last_s) begin
            idx_r   <= op_counts_down(op_r) ? (idx_r - LEN_W'(1)) : (idx_r + LEN_W'(1));
            first_r <= 1'b0;
        end else begin
            idx_r   <= idx_r;
            first_r <= first_r;
        end
    end

    // Output decode: the first byte takes its carry from flagC, later bytes from the chain
    always_comb begin
        cmdReady  = 1'b0;
        aluOp     = 3'd0;
        rightSel  = 1'b0;
        carryInEn = 1'b0;
        carryIn   = 1'b0;
        invOut    = 1'b0;
        aluResult = 1'b0;
        dstWe     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cmdReady = 1'b1;
            end
            ST_EXEC: begin
                busy      = 1'b1;
                aluOp     = op_r;
                rightSel  = rsel_r;
                invOut    = inv_r;
                carryInEn = first_r ? cie_r : 1'b1;
                carryIn   = first_r ? flagC : chain_c_s;
            end
            ST_WB: begin
                busy      = 1'b1;
                aluResult = 1'b1;
                dstWe     = 1'b1;
                invOut    = inv_r;
            end
            ST_DONE: begin
                cmdReady = 1'b1;
                done     = 1'b1;
            end
            default: begin
                cmdReady = 1'b0;
            end
        endcase
    end

    r88_alu_seq_flag_unit u_flag_unit (
        .clk       (sysClock),
        .rst_n     (sysReset_n),
        .clr       (accept_s),
        .wb_en     (in_wb_s),
        .commit    (commit_s),
        .carry_upd (carry_upd_s),
        .alu_carry (aluCarryOut),
        .int_d     (intD),
        .chain_c   (chain_c_s),
        .flag_c    (flagC),
        .flag_z    (flagZ),
        .flag_n    (flagN)
    );

endmodule
